pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 39 +++
 rtl/pipe_perf_cnt.sv | 40 ++++
 rtl/pipeline_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encodings, default timeout
// and the control-word type with its RUN-mode decode.
package pipeline_ctrl_pkg;

    localparam logic [1:0] StIdle    = 2'b00;
    localparam logic [1:0] StRun     = 2'b01;
    localparam logic [1:0] StMemWait = 2'b10;

    localparam int unsigned DefaultTimeout = 200;
    localparam int unsigned WaitW          = 8;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic memwb_write;
        logic ifid_flush;
        logic idex_bubble;
        logic mem_enable;
    } ctrl_t;

    // Control word for a non-memory-stall cycle; load-use beats branch because the
    // branch is re-resolved once the stalled instruction advances.
    function automatic ctrl_t run_ctrl(input logic load_use, input logic branch_taken,
                                       input logic mem_req);
        ctrl_t c;
        c.pc_write    = ~load_use;
        c.ifid_write  = ~load_use;
        c.idex_write  = 1'b1;
        c.exmem_write = 1'b1;
        c.memwb_write = 1'b1;
        c.ifid_flush  = branch_taken & ~load_use;
        c.idex_bubble = load_use;
        c.mem_enable  = mem_req;
        return c;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running performance counters: active cycles and stalled active cycles.
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             active_i,
    input  logic             stall_i,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (active_i) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
            if (stall_i) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: hazard stalls/flushes, data-memory wait with
// timeout abort, and performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_write_o,
    output logic             exmem_write_o,
    output logic             memwb_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             mem_enable_o,
    output logic [1:0]       state_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [WaitW-1:0] TimeoutCnt = WaitW'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             err_q, err_d;
    ctrl_t            ctrl;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        ctrl    = '0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (mem_req_i && !mem_ack_i) begin
                    // Miss: freeze everything this cycle and start waiting.
                    ctrl.mem_enable = 1'b1;
                    state_d         = StMemWait;
                    wait_d          = '0;
                end else begin
                    ctrl = run_ctrl(load_use_i, branch_taken_i, mem_req_i);
                end
            end
            StMemWait: begin
                if (mem_ack_i) begin
                    ctrl    = run_ctrl(load_use_i, branch_taken_i, 1'b1);
                    state_d = StRun;
                end else begin
                    ctrl.mem_enable = 1'b1;
                    if (wait_q == TimeoutCnt) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    pipe_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .active_i   (state_q != StIdle),
        .stall_i    (~ctrl.pc_write),
        .cycle_cnt_o(cycle_cnt_o),
        .stall_cnt_o(stall_cnt_o)
    );

    assign pc_write_o    = ctrl.pc_write;
    assign ifid_write_o  = ctrl.ifid_write;
    assign idex_write_o  = ctrl.idex_write;
    assign exmem_write_o = ctrl.exmem_write;
    assign memwb_write_o = ctrl.memwb_write;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_bubble_o = ctrl.idex_bubble;
    assign mem_enable_o  = ctrl.mem_enable;
    assign state_o       = state_q;
    assign err_o         = err_q;

endmodule
